fp_add_sched: RTL and testbench

- Round-robin scheduler that shares one combinational single-precision adder (fp_adder) among NUM_REQ requesters.
- Each requester has a valid/ready request port. Results return on one shared response port tagged with the requester ID.
- The scheduler registers the adder operands, captures the sum, and bypasses the adder when an operand is signed zero, because the adder does not handle zero.

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_add_sched_rr_arbiter.sv | 29 ++
 rtl/fp_add_sched.sv | 123 ++++++++++++
 tb/tb_fp_add_sched.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision field constants, zero test and scheduler state encoding.
package fp_pkg;

   localparam int unsigned FP_W  = 32;
   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;

   localparam int unsigned SIGN_POS = FP_W - 1;
   localparam int unsigned EXP_MSB  = FP_W - 2;
   localparam int unsigned EXP_LSB  = MAN_W;
   localparam int unsigned MAN_MSB  = MAN_W - 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } sched_state_t;

   // Signed zero: exponent and mantissa both clear, sign ignored.
   function automatic logic fp_is_zero(input logic [FP_W-1:0] x);
      return x[EXP_MSB:0] == '0;
   endfunction

endpackage

// File: rtl/fp_add_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above i_ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   always_comb begin : arb_search
      int unsigned j;
      j       = 0;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(i_ptr) + k) % N;
         if (!o_any && i_req[j]) begin
            o_any      = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/fp_add_sched.sv
// Round-robin scheduler sharing one external combinational fp adder; zero operands bypass it.
// Define FP_ADD_SCHED_STATS_EN to add stat_ops / stat_bypass / stat_stall counters.
module fp_add_sched
   import fp_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*FP_W-1:0] req_a,
   input  logic [NUM_REQ*FP_W-1:0] req_b,
   input  logic [NUM_REQ-1:0]      req_sub,
   output logic [FP_W-1:0]         add_a,
   output logic [FP_W-1:0]         add_b,
   input  logic [FP_W-1:0]         add_sum,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [FP_W-1:0]         rsp_sum,
   output logic                    busy
`ifdef FP_ADD_SCHED_STATS_EN
   ,
   output logic [31:0]             stat_ops,
   output logic [31:0]             stat_bypass,
   output logic [31:0]             stat_stall
`endif
);

   sched_state_t    r_state;
   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] r_tag;
   logic            r_zero_flag;
   logic [FP_W-1:0] r_bypass;

   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_idx;
   logic               w_any;
   logic               w_arb_en;
   logic               w_fire;
   logic [FP_W-1:0]    w_a;
   logic [FP_W-1:0]    w_b;
   logic [ID_W-1:0]    w_next_ptr;

   rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_arb_en   = !rst && ((r_state == S_IDLE) || (r_state == S_RESP && rsp_ready));
   assign req_ready  = w_arb_en ? w_grant : '0;
   assign w_fire     = w_arb_en && w_any;
   assign w_a        = req_a[FP_W*w_idx +: FP_W];
   assign w_b        = req_b[FP_W*w_idx +: FP_W] ^ {req_sub[w_idx], {(FP_W-1){1'b0}}};
   assign w_next_ptr = (32'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + ID_W'(1);
   assign busy       = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_tag       <= '0;
         r_zero_flag <= 1'b0;
         r_bypass    <= '0;
         add_a       <= '0;
         add_b       <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_sum     <= '0;
      end else begin
         case (r_state)
            S_IDLE:    r_state <= S_IDLE;
            S_ISSUE:   r_state <= S_CAPTURE;
            S_CAPTURE: begin
               rsp_sum   <= r_zero_flag ? r_bypass : add_sum;
               rsp_id    <= r_tag;
               rsp_valid <= 1'b1;
               r_state   <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default:   r_state <= S_IDLE;
         endcase
         // A grant (IDLE, or RESP with rsp_ready) overrides the state chosen above.
         if (w_fire) begin
            add_a       <= w_a;
            add_b       <= w_b;
            r_tag       <= w_idx;
            r_ptr       <= w_next_ptr;
            r_zero_flag <= fp_is_zero(w_a) || fp_is_zero(w_b);
            r_bypass    <= fp_is_zero(w_b) ? w_a : w_b;
            r_state     <= S_ISSUE;
         end
      end
   end

`ifdef FP_ADD_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_ops    <= '0;
         stat_bypass <= '0;
         stat_stall  <= '0;
      end else begin
         if (rsp_valid && rsp_ready)
            stat_ops <= stat_ops + 32'd1;
         if (r_state == S_CAPTURE && r_zero_flag)
            stat_bypass <= stat_bypass + 32'd1;
         if (rsp_valid && !rsp_ready && stat_stall != '1)
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fp_add_sched.sv
// Scoreboard bench for fp_add_sched with a table-driven stand-in for the external adder.
module tb_fp_add_sched;

   logic         clk;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic [3:0]   req_sub;
   logic [31:0]  add_a;
   logic [31:0]  add_b;
   logic [31:0]  add_sum;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [1:0]   rsp_id;
   logic [31:0]  rsp_sum;
   logic         busy;
`ifdef FP_ADD_SCHED_STATS_EN
   logic [31:0]  stat_ops;
   logic [31:0]  stat_bypass;
   logic [31:0]  stat_stall;
`endif

   logic force_dead;
   int   checks;
   int   errors;
   int   cyc;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] sum;
   } exp_t;

   exp_t sb[$];
   int   grant_log[$];
   int   rsp_cyc[$];

   fp_add_sched #(.NUM_REQ(4), .ID_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sum   (add_sum),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .busy      (busy)
`ifdef FP_ADD_SCHED_STATS_EN
      ,
      .stat_ops    (stat_ops),
      .stat_bypass (stat_bypass),
      .stat_stall  (stat_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Known sums for the directed cases, a scramble otherwise so a wrong operand shows up.
   function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         64'h3F800000_40000000: return 32'h40400000;
         64'h40400000_BF800000: return 32'h40000000;
         default:               return a ^ {b[15:0], b[31:16]} ^ 32'h12345678;
      endcase
   endfunction

   always_comb add_sum = force_dead ? 32'hDEADBEEF : fake_add(add_a, add_b);

   always @(negedge clk) begin : monitor
      logic [31:0] ma, mb, ms;
      exp_t e;
      cyc++;
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               ma = req_a[32*i +: 32];
               mb = req_b[32*i +: 32] ^ {req_sub[i], 31'b0};
               if (mb[30:0] == 31'd0)      ms = ma;
               else if (ma[30:0] == 31'd0) ms = mb;
               else                        ms = force_dead ? 32'hDEADBEEF : fake_add(ma, mb);
               e.id  = 2'(i);
               e.sum = ms;
               sb.push_back(e);
               grant_log.push_back(i);
            end
         end
         if (rsp_valid && rsp_ready) begin
            rsp_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_rsp id=%0d sum=%h", rsp_id, rsp_sum);
            end else begin
               e = sb.pop_front();
               if (rsp_id !== e.id || rsp_sum !== e.sum) begin
                  errors++;
                  $display("FAIL sb_rsp got id=%0d sum=%h exp id=%0d sum=%h",
                           rsp_id, rsp_sum, e.id, e.sum);
               end
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_sub[i]        = s;
   endtask

   task automatic wait_rsp;
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (rsp_valid) ok = 1'b1;
         else tick();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rsp_timeout got rsp_valid=0 exp 1");
      end
   endtask

   task automatic wait_idle;
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         if (sb.size() == 0 && !busy) ok = 1'b1;
         else tick();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL idle_timeout got pending=%0d busy=%b exp 0 0", sb.size(), busy);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_valid = 4'b1111;
      repeat (2) tick();
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl got ready=%b rsp_valid=%b busy=%b exp 0000 0 0",
                  req_ready, rsp_valid, busy);
      end
      checks++;
      if (add_a !== 32'h0 || add_b !== 32'h0 || rsp_id !== 2'd0 || rsp_sum !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got a=%h b=%h id=%0d sum=%h exp zeros", add_a, add_b, rsp_id, rsp_sum);
      end
      req_valid = 4'b0000;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic;
      rsp_ready = 1'b1;
      set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL basic_grant got %b exp 0001", req_ready);
      end
      tick();
      req_valid = 4'b0000;
      checks++;
      if (add_a !== 32'h3F800000 || add_b !== 32'h40000000 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_issue got a=%h b=%h busy=%b v=%b exp 3f800000 40000000 1 0",
                  add_a, add_b, busy, rsp_valid);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_early_rsp got rsp_valid=%b exp 0", rsp_valid);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'h40400000) begin
         errors++;
         $display("FAIL basic_rsp got v=%b id=%0d sum=%h exp 1 0 40400000", rsp_valid, rsp_id, rsp_sum);
      end
      wait_idle();
   endtask

   task automatic test_sub;
      set_req(2, 32'h40400000, 32'h3F800000, 1'b1);
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL sub_grant got %b exp 0100", req_ready);
      end
      tick();
      req_valid = 4'b0000;
      checks++;
      if (add_a !== 32'h40400000 || add_b !== 32'hBF800000) begin
         errors++;
         $display("FAIL sub_operands got a=%h b=%h exp 40400000 bf800000", add_a, add_b);
      end
      wait_rsp();
      checks++;
      if (rsp_id !== 2'd2 || rsp_sum !== 32'h40000000) begin
         errors++;
         $display("FAIL sub_rsp got id=%0d sum=%h exp 2 40000000", rsp_id, rsp_sum);
      end
      wait_idle();
   endtask

   task automatic test_bypass;
      logic [31:0] exp_sum [3];
      int          ids     [3];
      force_dead = 1'b1;
      exp_sum[0] = 32'h40400000; ids[0] = 1;
      exp_sum[1] = 32'h80000000; ids[1] = 1;
      exp_sum[2] = 32'h40400000; ids[2] = 3;
      for (int t = 0; t < 3; t++) begin
         case (t)
            0: set_req(1, 32'h00000000, 32'h40400000, 1'b0);
            1: set_req(1, 32'h80000000, 32'h00000000, 1'b0);
            default: set_req(3, 32'h40400000, 32'h00000000, 1'b1);
         endcase
         req_valid = 4'b0001 << ids[t];
         tick();
         req_valid = 4'b0000;
         wait_rsp();
         checks++;
         if (rsp_id !== 2'(ids[t]) || rsp_sum !== exp_sum[t]) begin
            errors++;
            $display("FAIL bypass_%0d got id=%0d sum=%h exp %0d %h", t, rsp_id, rsp_sum, ids[t], exp_sum[t]);
         end
         wait_idle();
      end
      force_dead = 1'b0;
   endtask

   task automatic test_back_to_back;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      grant_log.delete();
      rsp_cyc.delete();
      for (int i = 0; i < 4; i++)
         set_req(i, {8'h40, 8'(i), 16'h0100}, {8'h41, 8'(i), 16'h0000}, 1'b0);
      req_valid = 4'b1111;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (grant_log.size() >= 5) break;
      end
      req_valid = 4'b0000;
      wait_idle();
      checks++;
      if (grant_log.size() != 5 || rsp_cyc.size() != 5) begin
         errors++;
         $display("FAIL rr_count got grants=%0d rsps=%0d exp 5 5", grant_log.size(), rsp_cyc.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            checks++;
            if (grant_log[k] != k % 4) begin
               errors++;
               $display("FAIL rr_order[%0d] got %0d exp %0d", k, grant_log[k], k % 4);
            end
         end
         for (int k = 1; k < 5; k++) begin
            checks++;
            if (rsp_cyc[k] - rsp_cyc[k-1] != 3) begin
               errors++;
               $display("FAIL rr_spacing[%0d] got %0d exp 3", k, rsp_cyc[k] - rsp_cyc[k-1]);
            end
         end
      end
   endtask

   task automatic test_stall;
      logic [31:0] exp_sum;
      exp_sum = fake_add(32'h40A00000, 32'h40C00000);
      rsp_ready = 1'b0;
      set_req(3, 32'h40A00000, 32'h40C00000, 1'b0);
      req_valid = 4'b1000;
      tick();
      req_valid = 4'b0000;
      wait_rsp();
      set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
      req_valid = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== exp_sum || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL stall_hold[%0d] got v=%b id=%0d sum=%h ready=%b exp 1 3 %h 0000",
                     k, rsp_valid, rsp_id, rsp_sum, req_ready, exp_sum);
         end
      end
`ifdef FP_ADD_SCHED_STATS_EN
      checks++;
      if (stat_stall !== 32'd5) begin
         errors++;
         $display("FAIL stat_stall got %0d exp 5", stat_stall);
      end
`endif
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL b2b_grant got %b exp 0001", req_ready);
      end
      tick();
      req_valid = 4'b0000;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1 || add_a !== 32'h3F800000) begin
         errors++;
         $display("FAIL b2b_issue got v=%b busy=%b a=%h exp 0 1 3f800000", rsp_valid, busy, add_a);
      end
      wait_idle();
   endtask

   task automatic test_reset_mid;
      int seen;
      set_req(1, 32'h41000000, 32'h41100000, 1'b0);
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0000;
      rst = 1'b1;
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || add_a !== 32'h0 || req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_state got v=%b busy=%b a=%h ready=%b exp 0 0 0 0000",
                  rsp_valid, busy, add_a, req_ready);
      end
      rst = 1'b0;
      sb.delete();
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (rsp_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL rstmid_ghost got %0d response cycles exp 0", seen);
      end
      set_req(2, 32'h41200000, 32'h41300000, 1'b0);
      set_req(3, 32'h41400000, 32'h41500000, 1'b0);
      req_valid = 4'b1111;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rstmid_ptr got %b exp 0001", req_ready);
      end
      tick();
      req_valid = 4'b0000;
      wait_idle();
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      cyc        = 0;
      force_dead = 1'b0;
      rst        = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_sub    = '0;
      rsp_ready  = 1'b0;
      test_reset();
      test_basic();
      test_sub();
      test_bypass();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
